// File: rtl/tt_um_hoene_protocol_check.sv
// rtl/tt_um_hoene_protocol_check.sv - serial LED stream integrity checker (parity / CRC-8)
module tt_um_hoene_protocol_check #(
    parameter int WORD_BITS = 25,
    parameter int CNT_W     = 8,
    parameter int IDX_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_data,
    input  logic             in_clk,
    input  logic             in_sync,
    input  logic [1:0]       mode,
    input  logic             clr_err,
    output logic             error,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count,
    output logic [IDX_W-1:0] first_err_word,
    output logic             frame_done,
    output logic             frame_ok
);
    localparam int BW = (WORD_BITS > 2) ? $clog2(WORD_BITS) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WORD_BITS - 1);

    logic             sync_q;
    logic [1:0]       mode_q;
    logic [BW-1:0]    bit_cnt;
    logic [IDX_W-1:0] word_idx;
    logic             acc;
    logic [7:0]       crc;
    logic [3:0]       crc_bits;
    logic             frame_err;

    logic             start, fin, bit_en;
    logic [1:0]       cur_mode;
    logic [BW-1:0]    b_bit, n_bit;
    logic [IDX_W-1:0] b_idx, n_idx;
    logic             b_acc, n_acc;
    logic [7:0]       b_crc, n_crc;
    logic [3:0]       b_cbits, n_cbits;
    logic             b_ferr;
    logic             par_bad, end_err, ev, fb, word_par;
    logic [CNT_W-1:0] base_cnt;

    assign start  = in_sync & ~sync_q;
    assign fin    = ~in_sync & sync_q;
    assign bit_en = in_clk & in_sync;

    // On the frame-start cycle the per-frame state is seen as freshly cleared,
    // so a strobe coinciding with the rising sync is counted as the first bit.
    always_comb begin
        cur_mode = start ? mode : mode_q;
        b_bit    = start ? '0 : bit_cnt;
        b_idx    = start ? '0 : word_idx;
        b_acc    = start ? 1'b0 : acc;
        b_crc    = start ? 8'h00 : crc;
        b_cbits  = start ? 4'd0 : crc_bits;
        b_ferr   = start ? 1'b0 : frame_err;
        n_bit    = b_bit;
        n_idx    = b_idx;
        n_acc    = b_acc;
        n_crc    = b_crc;
        n_cbits  = b_cbits;
        par_bad  = 1'b0;
        fb       = b_crc[7] ^ in_data;
        word_par = b_acc ^ in_data;
        if (bit_en) begin
            n_acc = word_par;
            n_crc = {b_crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            if (b_cbits != 4'd8) n_cbits = b_cbits + 4'd1;
            if (b_bit == LAST_BIT) begin
                n_bit   = '0;
                n_acc   = 1'b0;
                if (b_idx != {IDX_W{1'b1}}) n_idx = b_idx + 1'b1;
                par_bad = (cur_mode == 2'b01 || cur_mode == 2'b10) &&
                          (word_par != (cur_mode == 2'b10));
            end else begin
                n_bit = b_bit + 1'b1;
            end
        end
    end

    assign end_err = fin && (((mode_q == 2'b01 || mode_q == 2'b10) && bit_cnt != '0) ||
                             (mode_q == 2'b11 && (crc != 8'h00 || crc_bits != 4'd8)));
    assign ev       = par_bad | end_err;
    assign base_cnt = clr_err ? '0 : err_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q         <= 1'b0;
            mode_q         <= 2'b00;
            bit_cnt        <= '0;
            word_idx       <= '0;
            acc            <= 1'b0;
            crc            <= 8'h00;
            crc_bits       <= 4'd0;
            frame_err      <= 1'b0;
            error          <= 1'b0;
            err_sticky     <= 1'b0;
            err_count      <= '0;
            first_err_word <= '0;
            frame_done     <= 1'b0;
            frame_ok       <= 1'b0;
        end else begin
            sync_q     <= in_sync;
            if (start) mode_q <= mode;
            bit_cnt    <= n_bit;
            word_idx   <= n_idx;
            acc        <= n_acc;
            crc        <= n_crc;
            crc_bits   <= n_cbits;
            frame_err  <= b_ferr | par_bad;
            error      <= ev;
            frame_done <= fin;
            if (fin) frame_ok <= ~(frame_err | end_err);
            // An event in the same cycle as clr_err lands on the cleared base.
            if (ev) begin
                err_sticky <= 1'b1;
                err_count  <= (base_cnt == {CNT_W{1'b1}}) ? base_cnt : base_cnt + 1'b1;
                if (base_cnt == '0) first_err_word <= b_idx;
            end else if (clr_err) begin
                err_sticky     <= 1'b0;
                err_count      <= '0;
                first_err_word <= '0;
            end
        end
    end
endmodule
